// File: rtl/lbp_code_collector.sv
// lbp_code_collector
// Assembles one NBITS-wide local-binary-pattern code from a serial stream of
// comparator decisions and queues finished codes in a small first-word
// fall-through FIFO.
//
// Ports
//   wb_clk_i      single clock, all state on its rising edge
//   wb_rst_i      synchronous active-high reset
//   start_i       pulse: begin one code acquisition (honoured only when idle)
//   cmp_i         comparator output, asynchronous, double-flop synchronized
//   sample_i      pulse: comparator settled, capture the next bit (LSB first)
//   pair_sel_o    index of the photodiode pair under comparison (0 when not acquiring)
//   busy_o        acquisition or push in progress
//   code_o        head-of-FIFO code (0 when empty)
//   code_valid_o  FIFO not empty
//   code_ready_i  consumer pops the head when code_valid_o is also high
//   count_o       FIFO occupancy
//   overflow_o    sticky: a finished code was dropped because the FIFO was full
//   ovf_clr_i     clears overflow_o (a simultaneous overflow wins)
//
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module lbp_code_collector #(
    parameter int NBITS = 12,
    parameter int DEPTH = 4
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     start_i,
    input  logic                     cmp_i,
    input  logic                     sample_i,
    output logic [3:0]               pair_sel_o,
    output logic                     busy_o,
    output logic [NBITS-1:0]         code_o,
    output logic                     code_valid_o,
    input  logic                     code_ready_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    input  logic                     ovf_clr_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [3:0]       LAST_IDX = 4'(NBITS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        PUSH = 2'd2
    } state_e;

    logic             cmp_meta_q;
    logic             cmp_sync_q;
    state_e           state_q;
    logic [3:0]       idx_q;
    logic [NBITS-1:0] shift_q;
    logic             busy_q;
    logic [3:0]       pair_sel_q;

    logic [NBITS-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [NBITS-1:0] code_q, code_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;

    logic             push_s;
    logic             pop_s;
    logic             push_ok_s;
    logic             drop_s;

    // Two-flop synchronizer for the asynchronous comparator output.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cmp_meta_q <= 1'b0;
            cmp_sync_q <= 1'b0;
        end else begin
            cmp_meta_q <= cmp_i;
            cmp_sync_q <= cmp_meta_q;
        end
    end

    // Acquisition FSM with its registered busy/pair-select outputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            idx_q      <= 4'd0;
            shift_q    <= {NBITS{1'b0}};
            busy_q     <= 1'b0;
            pair_sel_q <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q    <= ACQ;
                        idx_q      <= 4'd0;
                        shift_q    <= {NBITS{1'b0}};
                        busy_q     <= 1'b1;
                        pair_sel_q <= 4'd0;
                    end
                end
                ACQ: begin
                    if (sample_i) begin
                        shift_q[idx_q] <= cmp_sync_q;
                        idx_q          <= idx_q + 4'd1;
                        if (idx_q == LAST_IDX) begin
                            // Code complete: pair_sel drops to 0 as we leave ACQ.
                            state_q    <= PUSH;
                            pair_sel_q <= 4'd0;
                        end else begin
                            pair_sel_q <= idx_q + 4'd1;
                        end
                    end
                end
                PUSH: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    busy_q     <= 1'b0;
                    pair_sel_q <= 4'd0;
                end
            endcase
        end
    end

    // FIFO next-state: push/pop arbitration, occupancy and next head word.
    always_comb begin
        pop_s     = code_ready_i && (count_q != ZERO_CNT);
        push_s    = (state_q == PUSH);
        // A full FIFO still accepts the push when the head leaves in the same cycle.
        push_ok_s = push_s && ((count_q != FULL_CNT) || pop_s);
        drop_s    = push_s && !push_ok_s;

        wr_ptr_d = push_ok_s ? (wr_ptr_q + PTR_W'(1'b1)) : wr_ptr_q;
        rd_ptr_d = pop_s     ? (rd_ptr_q + PTR_W'(1'b1)) : rd_ptr_q;

        if (push_ok_s && !pop_s) begin
            count_d = count_q + CNT_W'(1'b1);
        end else if (!push_ok_s && pop_s) begin
            count_d = count_q - CNT_W'(1'b1);
        end else begin
            count_d = count_q;
        end

        valid_d = (count_d != ZERO_CNT);

        // Head after this edge; if it is the slot being written now, bypass the memory.
        if (count_d == ZERO_CNT) begin
            code_d = {NBITS{1'b0}};
        end else if (push_ok_s && (wr_ptr_q == rd_ptr_d)) begin
            code_d = shift_q;
        end else begin
            code_d = mem_q[rd_ptr_d];
        end

        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // FIFO storage, pointers and registered head/status outputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {NBITS{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= ZERO_CNT;
            code_q   <= {NBITS{1'b0}};
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= shift_q;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            code_q   <= code_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign pair_sel_o   = pair_sel_q;
    assign busy_o       = busy_q;
    assign code_o       = code_q;
    assign code_valid_o = valid_q;
    assign count_o      = count_q;
    assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_lbp_code_collector.sv
// Directed bench for lbp_code_collector. A queue-based model of the collector
// predicts every output each cycle; literal expectations pin key scenarios.
module tb_lbp_code_collector;

    localparam int NBITS = 12;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        cmp = 1'b0;
    logic        sample = 1'b0;
    logic        rdy = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [3:0]  pair_sel;
    logic        busy;
    logic [11:0] code;
    logic        code_valid;
    logic [2:0]  count;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    lbp_code_collector #(.NBITS(NBITS), .DEPTH(DEPTH)) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .start_i      (start),
        .cmp_i        (cmp),
        .sample_i     (sample),
        .pair_sel_o   (pair_sel),
        .busy_o       (busy),
        .code_o       (code),
        .code_valid_o (code_valid),
        .code_ready_i (rdy),
        .count_o      (count),
        .overflow_o   (overflow),
        .ovf_clr_i    (ovf_clr)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int          m_q[$];
    logic [11:0] m_code = 12'h000;
    int          m_nb = 0;
    bit          m_acq = 1'b0;
    bit          m_pend = 1'b0;
    bit          m_ovf = 1'b0;
    bit          m_h1 = 1'b0;     // cmp_i one cycle back
    bit          m_h2 = 1'b0;     // cmp_i two cycles back: what a strobe captures
    bit          m_live = 1'b0;

    always @(posedge clk) begin
        bit pop_now;
        bit dropped;
        if (rst) begin
            m_q.delete();
            m_code = 12'h000;
            m_nb   = 0;
            m_acq  = 1'b0;
            m_pend = 1'b0;
            m_ovf  = 1'b0;
            m_h1   = 1'b0;
            m_h2   = 1'b0;
            m_live = 1'b1;
        end else begin
            pop_now = rdy && (m_q.size() > 0);
            dropped = 1'b0;
            if (pop_now) void'(m_q.pop_front());
            if (m_pend) begin
                if (m_q.size() >= DEPTH) dropped = 1'b1;
                else m_q.push_back(int'(m_code));
            end
            if (dropped) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;

            if (m_pend) begin
                m_pend = 1'b0;
            end else if (m_acq) begin
                if (sample) begin
                    m_code[m_nb] = m_h2;
                    m_nb = m_nb + 1;
                    if (m_nb == NBITS) begin
                        m_acq  = 1'b0;
                        m_pend = 1'b1;
                    end
                end
            end else if (start) begin
                m_acq  = 1'b1;
                m_nb   = 0;
                m_code = 12'h000;
            end
            m_h2 = m_h1;
            m_h1 = cmp;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            check("m_busy", 32'(busy), 32'(m_acq || m_pend));
            check("m_pair_sel", 32'(pair_sel), m_acq ? m_nb : 0);
            check("m_valid", 32'(code_valid), 32'(m_q.size() > 0));
            check("m_code", 32'(code), (m_q.size() > 0) ? m_q[0] : 0);
            check("m_count", 32'(count), m_q.size());
            check("m_overflow", 32'(overflow), 32'(m_ovf));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Put v on cmp_i, wait lag cycles, then strobe sample_i for one cycle.
    task automatic sample_lag(input logic v, input int lag);
        cmp = v;
        repeat (lag) tick();
        sample = 1'b1;
        tick();
        sample = 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Full acquisition; returns during the PUSH cycle.
    task automatic acquire(input logic [11:0] c);
        start_pulse();
        for (int i = 0; i < NBITS; i++) sample_lag(c[i], 2);
    endtask

    task automatic pop();
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
    endtask

    logic [11:0] ovf_codes [5];
    logic [11:0] fp_codes [5];
    logic [11:0] pat;
    logic        sync_v [12];
    int          sync_lag [12];

    initial begin
        ovf_codes = '{12'h123, 12'h456, 12'h789, 12'hABC, 12'hDEF};
        fp_codes  = '{12'h111, 12'h222, 12'h333, 12'h444, 12'h555};
        sync_v    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        sync_lag  = '{1, 2, 1, 1, 1, 2, 1, 3, 2, 1, 2, 2};

        // Reset
        rst = 1'b1;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(code_valid), 32'd0);
        check("rst_code", 32'(code), 32'd0);
        rst = 1'b0;
        tick();

        // Basic code and push latency
        acquire(12'hA5C);
        check("basic_valid_early", 32'(code_valid), 32'd0);
        check("basic_busy_push", 32'(busy), 32'd1);
        tick();
        check("basic_valid", 32'(code_valid), 32'd1);
        check("basic_code", 32'(code), 32'hA5C);
        check("basic_count", 32'(count), 32'd1);
        check("basic_busy_after", 32'(busy), 32'd0);
        pop();
        check("basic_drained", 32'(count), 32'd0);

        // Overflow: five codes, no consumer
        for (int k = 0; k < 5; k++) begin
            acquire(ovf_codes[k]);
            tick();
            tick();
        end
        check("ovf_count", 32'(count), 32'd4);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_head", 32'(code), 32'h123);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);
        for (int k = 0; k < 4; k++) begin
            check("ovf_order", 32'(code), 32'(ovf_codes[k]));
            pop();
        end
        check("ovf_drained", 32'(count), 32'd0);

        // Full FIFO with pop during PUSH
        for (int k = 0; k < 4; k++) begin
            acquire(fp_codes[k]);
            tick();
            tick();
        end
        acquire(fp_codes[4]);
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        check("fullpop_count", 32'(count), 32'd4);
        check("fullpop_ovf", 32'(overflow), 32'd0);
        check("fullpop_head", 32'(code), 32'h222);
        for (int k = 1; k < 5; k++) begin
            check("fullpop_order", 32'(code), 32'(fp_codes[k]));
            pop();
        end

        // Mid-acquisition reset, with other inputs active during reset
        start_pulse();
        pat = 12'hFFF;
        for (int i = 0; i < 6; i++) sample_lag(pat[i], 2);
        check("midrst_pair_sel_pre", 32'(pair_sel), 32'd6);
        rst = 1'b1;
        start = 1'b1;
        sample = 1'b1;
        rdy = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        sample = 1'b0;
        rdy = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_pair_sel", 32'(pair_sel), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        tick();
        acquire(12'h3C5);
        tick();
        check("midrst_clean_code", 32'(code), 32'h3C5);
        check("midrst_clean_count", 32'(count), 32'd1);
        pop();

        // Ignored start during ACQ and sample in IDLE
        pat = 12'h5A5;
        start_pulse();
        for (int i = 0; i < 3; i++) sample_lag(pat[i], 2);
        check("ign_pair_sel_pre", 32'(pair_sel), 32'd3);
        start_pulse();
        check("ign_pair_sel_start", 32'(pair_sel), 32'd3);
        for (int i = 3; i < NBITS; i++) sample_lag(pat[i], 2);
        tick();
        check("ign_code", 32'(code), 32'h5A5);
        check("ign_count", 32'(count), 32'd1);
        for (int j = 0; j < 3; j++) sample_lag(1'b1, 1);
        tick();
        check("ign_idle_count", 32'(count), 32'd1);
        check("ign_idle_busy", 32'(busy), 32'd0);
        pop();
        rdy = 1'b1;
        repeat (2) tick();
        rdy = 1'b0;
        check("empty_pop_count", 32'(count), 32'd0);
        check("empty_pop_valid", 32'(code_valid), 32'd0);

        // Synchronizer latency: lag 1 captures the old level, lag >= 2 the new
        cmp = 1'b0;
        repeat (3) tick();
        start_pulse();
        for (int i = 0; i < NBITS; i++) sample_lag(sync_v[i], sync_lag[i]);
        tick();
        check("sync_code", 32'(code), 32'h086);
        pop();
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lbp_code_collector.md
LBP_CODE_COLLECTOR -- requirements
Module: lbp_code_collector

Interface
REQ-001 SHALL have parameter NBITS, default 12, giving the number of comparator decisions per code (one per photodiode pair).
REQ-002 SHALL have parameter DEPTH, default 4, giving the output FIFO entries; DEPTH SHALL be a power of two.
REQ-003 SHALL have port wb_clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port wb_rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start_i, input, 1 bit: one-cycle pulse that starts one code acquisition.
REQ-006 SHALL have port cmp_i, input, 1 bit: comparator output from the analog macro, asynchronous to wb_clk_i.
REQ-007 SHALL have port sample_i, input, 1 bit: one-cycle strobe from the sequencer meaning "comparator settled, take bit".
REQ-008 SHALL have port pair_sel_o, output, 4 bits: index (0..NBITS-1) of the pair under comparison.
REQ-009 SHALL have port busy_o, output, 1 bit: high while an acquisition is in progress.
REQ-010 SHALL have port code_o, output, NBITS bits: head-of-FIFO code.
REQ-011 SHALL have port code_valid_o, output, 1 bit: FIFO not empty.
REQ-012 SHALL have port code_ready_i, input, 1 bit: consumer pops the head when code_valid_o and code_ready_i are both high.
REQ-013 SHALL have port count_o, output, clog2(DEPTH)+1 bits: FIFO occupancy.
REQ-014 SHALL have port overflow_o, output, 1 bit: sticky flag, set when a code is dropped.
REQ-015 SHALL have port ovf_clr_i, input, 1 bit: clears overflow_o.

Function
REQ-016 SHALL synchronize cmp_i through two flops; only the synchronized value (cmp_s) SHALL be used.
REQ-017 SHALL implement a state machine with states IDLE, ACQ and PUSH.
REQ-018 In IDLE, start_i SHALL clear the shift register and bit index and move the FSM to ACQ; sample_i SHALL be ignored.
REQ-019 In ACQ, each sample_i SHALL write cmp_s into code bit [index] (LSB first) and increment index.
REQ-020 In ACQ, the sample_i that fills bit NBITS-1 SHALL move the FSM to PUSH.
REQ-021 In ACQ and PUSH, start_i SHALL be ignored.
REQ-022 In PUSH, the FSM SHALL write the assembled code into the FIFO for one cycle, then return to IDLE.
REQ-023 A code SHALL appear on code_o/code_valid_o (first-word fall-through) on the edge that ends PUSH, i.e. 2 cycles after the final sample_i cycle, given an empty FIFO.
REQ-024 PUSH with FIFO full and no pop that cycle: the code SHALL be dropped, overflow_o set, and FIFO contents unchanged.
REQ-025 PUSH with FIFO full and a pop that same cycle: the push SHALL succeed and count_o stay at DEPTH.
REQ-026 Push and pop in the same non-full, non-empty cycle: count_o SHALL be unchanged and order preserved.
REQ-027 A pop with the FIFO empty SHALL have no effect; count_o SHALL never underflow.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH.
REQ-029 pair_sel_o SHALL equal the current bit index in ACQ and 0 otherwise.
REQ-030 busy_o SHALL be high in ACQ and PUSH.
REQ-031 ovf_clr_i SHALL clear overflow_o; if an overflow occurs in the same cycle, set SHALL win.

Reset
REQ-032 On wb_rst_i high, the FSM SHALL enter IDLE and the synchronizer, shift register, index, pointers, count_o, overflow_o, busy_o, pair_sel_o, code_valid_o and code_o SHALL all become 0, including mid-acquisition.
REQ-033 A partially assembled code SHALL be discarded by reset and never pushed.
REQ-034 start_i, sample_i and code_ready_i SHALL be ignored in a cycle where wb_rst_i is high.

Verification
REQ-035 Basic code: start_i, then 12 sample_i with cmp_i held to give bit pattern 0xA5C (LSB first) -> code_o=12'hA5C, code_valid_o rises 2 cycles after the 12th strobe, count_o=1, busy_o low afterwards.
REQ-036 Overflow: 5 acquisitions with code_ready_i=0 -> count_o=4, overflow_o=1, codes 1-4 retained in order; ovf_clr_i -> overflow_o=0.
REQ-037 Full with pop: FIFO full and code_ready_i=1 during PUSH -> oldest code popped, new code stored, count_o=4, overflow_o=0.
REQ-038 Mid-acquisition reset: wb_rst_i after 6 strobes -> busy_o=0, pair_sel_o=0, count_o=0; next full acquisition yields a clean code.
REQ-039 Ignored inputs: start_i during ACQ and sample_i in IDLE -> no index change and no extra push.
REQ-040 Synchronizer: cmp_i toggled 1 cycle before sample_i -> the old value is captured; toggled 2 or more cycles before -> the new value is captured.
